// File: rtl/irq_ack_ctrl.sv
// Interrupt responder: counts sample-ready events and raises a level irq, coalesced by threshold or timeout.
// Host acknowledges consumed events over a small Avalon-MM register slave.
module irq_ack_ctrl #(
  parameter int CNT_W       = 16,
  parameter int TMO_W       = 24,
  parameter int HOLDOFF_CYC = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        evt_valid,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq,
  output logic        irqflagtap
);

  localparam int HO_W = $clog2(HOLDOFF_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_FIRED   = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic [TMO_W-1:0] timeout_q, timeout_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [HO_W-1:0]  hold_q, hold_d;
  logic             ovf_q, ovf_d;
  logic             enable_q, enable_d;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             wr_ack, wr_ctrl, wr_thresh, wr_tmo;
  logic             pend_max, evt_eff, tmo_hit;
  logic [CNT_W-1:0] sum, ack_n;
  logic [31:0]      rd_mux;

  always_comb begin
    wr_ack    = avs_write && (avs_address == 3'd1);
    wr_ctrl   = avs_write && (avs_address == 3'd2);
    wr_thresh = avs_write && (avs_address == 3'd3);
    wr_tmo    = avs_write && (avs_address == 3'd4);

    // An event arriving at saturation is dropped and only flags overflow.
    pend_max  = &pending_q;
    evt_eff   = evt_valid && !pend_max;
    sum       = pending_q + CNT_W'(evt_eff);
    ack_n     = wr_ack ? avs_writedata[CNT_W-1:0] : '0;
    pending_d = (ack_n >= sum) ? '0 : (sum - ack_n);

    ovf_d = ovf_q;
    if (wr_ctrl && avs_writedata[1]) ovf_d = 1'b0;
    if (evt_valid && pend_max)       ovf_d = 1'b1;

    enable_d  = wr_ctrl ? avs_writedata[0] : enable_q;
    thresh_d  = thresh_q;
    if (wr_thresh)
      thresh_d = (avs_writedata[CNT_W-1:0] == '0) ? CNT_W'(1) : avs_writedata[CNT_W-1:0];
    timeout_d = wr_tmo ? avs_writedata[TMO_W-1:0] : timeout_q;

    tmo_hit = (timeout_q != '0) && (timer_q >= (timeout_q - TMO_W'(1)));
  end

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (pending_d != '0) state_d = S_ARMED;
      end
      S_ARMED: begin
        timer_d = (&timer_q) ? timer_q : (timer_q + TMO_W'(1));
        if (pending_d == '0)
          state_d = S_IDLE;
        else if (enable_q && ((pending_q >= thresh_q) || tmo_hit))
          state_d = S_FIRED;
      end
      S_FIRED: begin
        if (wr_ack && (pending_d < thresh_q)) begin
          state_d = S_HOLDOFF;
          hold_d  = HO_W'(HOLDOFF_CYC - 1);
        end else if (!enable_d) begin
          state_d = S_ARMED;
        end
      end
      S_HOLDOFF: begin
        if (hold_q == '0)
          state_d = (pending_d != '0) ? S_ARMED : S_IDLE;
        else
          hold_d = hold_q - HO_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    irq_d = (state_d == S_FIRED);
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0: begin
        rd_mux[CNT_W-1:0] = pending_q;
        rd_mux[16]        = ovf_q;
        rd_mux[17]        = irq_q;
        rd_mux[19:18]     = state_q;
      end
      3'd2:    rd_mux[0] = enable_q;
      3'd3:    rd_mux    = 32'(thresh_q);
      3'd4:    rd_mux    = 32'(timeout_q);
      default: rd_mux    = '0;
    endcase
    rdata_d = avs_read ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      thresh_q  <= CNT_W'(1);
      timeout_q <= '0;
      timer_q   <= '0;
      hold_q    <= '0;
      ovf_q     <= 1'b0;
      enable_q  <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      thresh_q  <= thresh_d;
      timeout_q <= timeout_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      ovf_q     <= ovf_d;
      enable_q  <= enable_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;
  assign irqflagtap   = irq_q;

endmodule

// File: tb/tb_irq_ack_ctrl.sv
// Directed self-checking bench for irq_ack_ctrl; expected values are hand-computed.
module tb_irq_ack_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        evt_valid = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;
  logic        irqflagtap;

  int total = 0;
  int bad   = 0;

  irq_ack_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .evt_valid    (evt_valid),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq),
    .irqflagtap   (irqflagtap)
  );

  always #10 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic pulse();
    @(negedge clk);
    evt_valid = 1'b1;
    @(negedge clk);
    evt_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset_val();
    logic [31:0] d;
    total++;
    if (irq !== 1'b0 || irqflagtap !== 1'b0) begin
      bad++; $display("FAIL reset_irq: got irq=%b tap=%b want 0/0", irq, irqflagtap);
    end
    rd(3'd0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want 00000000", d); end
    rd(3'd3, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL reset_thresh: got %h want 00000001", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    wr(3'd3, 32'h0);
    rd(3'd3, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL thresh_zero: got %h want 00000001", d); end
    wr(3'd4, 32'hAB123456);
    rd(3'd4, d);
    total++;
    if (d !== 32'h00123456) begin bad++; $display("FAIL timeout_rw: got %h want 00123456", d); end
    idle(3);
    total++;
    if (avs_readdata !== 32'h00123456) begin
      bad++; $display("FAIL rdata_hold: got %h want 00123456", avs_readdata);
    end
    wr(3'd2, 32'h3);
    rd(3'd2, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL ctrl_rw: got %h want 00000001", d); end
    wr(3'd5, 32'hFFFFFFFF);
    rd(3'd5, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL addr5: got %h want 00000000", d); end
    wr(3'd4, 32'h0);
  endtask

  task automatic test_thresh();
    logic [31:0] d;
    wr(3'd2, 32'h1);
    wr(3'd3, 32'h4);
    for (int i = 0; i < 3; i++) begin
      pulse();
      idle(9);
    end
    pulse();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL thresh_early: got irq=%b want 0", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b1 || irqflagtap !== 1'b1) begin
      bad++; $display("FAIL thresh_fire: got irq=%b tap=%b want 1/1", irq, irqflagtap);
    end
    rd(3'd0, d);
    total++;
    if (d !== 32'h000A0004) begin bad++; $display("FAIL thresh_status: got %h want 000A0004", d); end
  endtask

  task automatic test_ack();
    logic [31:0] d;
    int hi;
    wr(3'd1, 32'h4);
    hi = 0;
    for (int i = 0; i < 9; i++) begin
      if (irq !== 1'b0) hi++;
      if (i < 8) @(negedge clk);
    end
    total++;
    if (hi != 0) begin bad++; $display("FAIL ack_holdoff: got %0d high cycles want 0", hi); end
    rd(3'd0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL ack_status: got %h want 00000000", d); end
  endtask

  task automatic test_timeout();
    int first;
    wr(3'd3, 32'd100);
    wr(3'd4, 32'd50);
    pulse();
    first = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (irq === 1'b1 && first == 0) first = k;
    end
    total++;
    if (first != 50) begin bad++; $display("FAIL tmo_latency: got %0d want 50", first); end
    wr(3'd1, 32'h1);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL tmo_ack: got irq=%b want 0", irq); end
    idle(10);
  endtask

  task automatic test_ack_math();
    logic [31:0] d;
    wr(3'd4, 32'h0);
    repeat (3) pulse();
    @(negedge clk);
    evt_valid = 1'b1; avs_address = 3'd1; avs_writedata = 32'h1; avs_write = 1'b1;
    @(negedge clk);
    evt_valid = 1'b0; avs_write = 1'b0;
    rd(3'd0, d);
    total++;
    if (d !== 32'h00040003) begin bad++; $display("FAIL evt_and_ack: got %h want 00040003", d); end
    wr(3'd1, 32'h1);
    wr(3'd1, 32'd10);
    rd(3'd0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL ack_clamp: got %h want 00000000", d); end
  endtask

  task automatic test_saturate();
    logic [31:0] d;
    wr(3'd2, 32'h0);
    @(negedge clk);
    evt_valid = 1'b1;
    repeat (65535) @(negedge clk);
    avs_address = 3'd2; avs_writedata = 32'h2; avs_write = 1'b1;
    @(negedge clk);
    evt_valid = 1'b0; avs_write = 1'b0;
    rd(3'd0, d);
    total++;
    if (d !== 32'h0005FFFF) begin bad++; $display("FAIL sat_ovf: got %h want 0005FFFF", d); end
    wr(3'd2, 32'h3);
    rd(3'd0, d);
    total++;
    if (d[16:0] !== 17'h0FFFF) begin bad++; $display("FAIL ovf_clear: got %h want 0FFFF", d[16:0]); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL sat_fire: got irq=%b want 1", irq); end
  endtask

  task automatic test_enable_drop();
    logic [31:0] d;
    wr(3'd2, 32'h0);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL en_drop: got irq=%b want 0", irq); end
    rd(3'd0, d);
    total++;
    if (d !== 32'h0004FFFF) begin bad++; $display("FAIL en_drop_status: got %h want 0004FFFF", d); end
    wr(3'd2, 32'h1);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL en_set_early: got irq=%b want 0", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL en_set_fire: got irq=%b want 1", irq); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    @(negedge clk);
    #5 reset = 1'b1;
    #1;
    total++;
    if (irq !== 1'b0 || irqflagtap !== 1'b0) begin
      bad++; $display("FAIL async_irq: got irq=%b tap=%b want 0/0", irq, irqflagtap);
    end
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (avs_readdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 00000000", avs_readdata); end
    rd(3'd0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rst_status: got %h want 00000000", d); end
    rd(3'd2, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rst_ctrl: got %h want 00000000", d); end
    rd(3'd3, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL rst_thresh: got %h want 00000001", d); end
    rd(3'd4, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rst_timeout: got %h want 00000000", d); end
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    test_reset_val();
    test_regs();
    test_thresh();
    test_ack();
    test_timeout();
    test_ack_math();
    test_saturate();
    test_enable_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
